// File: rtl/fifomem_thresh.sv
// Synchronous FIFO of any depth with almost-full/almost-empty thresholds, an occupancy
// count, sticky overflow/underflow flags and a selectable registered or FWFT read path.
module fifomem_thresh #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = 6,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       almost_full,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       empty,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       clr_err,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_wr_ptr_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Status flags are pure decodes of the registered count.
    assign full         = (r_count == CNT_W'(DEPTH));
    assign empty        = (r_count == CNT_W'(0));
    assign almost_full  = (r_count >= CNT_W'(AF_LEVEL));
    assign almost_empty = (r_count <= CNT_W'(AE_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en & ~full;
    assign w_rd_acc = rd_en & ~empty;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (w_wr_acc) begin
            w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
        end
        if (w_rd_acc) begin
            w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
        end
        if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_wr_acc && w_rd_acc) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Sticky errors: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (rd_en && empty) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Storage is deliberately left unreset; contents are only observable via the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data = empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_rd_data <= '0;
                end else if (w_rd_acc) begin
                    r_rd_data <= r_mem[r_rd_ptr];
                end
            end
            assign rd_data = r_rd_data;
        end
    endgenerate

endmodule

// File: tb/tb_fifomem_thresh.sv
// Bench for fifomem_thresh: three instances (depth 8 registered, depth 6 registered,
// depth 8 FWFT) driven by shared inputs and tracked by a list-based reference model.
module tb_fifomem_thresh;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       wr_en   = 1'b0;
    logic       rd_en   = 1'b0;
    logic       clr_err = 1'b0;
    logic [3:0] wr_data = 4'h0;

    logic       full [3];
    logic       af   [3];
    logic       empty[3];
    logic       ae   [3];
    logic       ovf  [3];
    logic       unf  [3];
    logic [3:0] rd   [3];
    logic [3:0] cnt0;
    logic [2:0] cnt1;
    logic [3:0] cnt2;
    logic [13:0] obs [3];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: occupancy list per instance, head at index 0.
    int         mdp [3] = '{8, 6, 8};
    int         maf [3] = '{6, 5, 6};
    int         mae [3] = '{2, 1, 2};
    int         mfw [3] = '{0, 0, 1};
    int         mcnt[3];
    logic [3:0] mdat[3][8];
    bit         movf[3];
    bit         munf[3];
    logic [3:0] mrd [3];

    always #5 clk = ~clk;

    fifomem_thresh #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_d0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full[0]),
        .almost_full(af[0]), .rd_en(rd_en), .rd_data(rd[0]), .empty(empty[0]),
        .almost_empty(ae[0]), .count(cnt0), .clr_err(clr_err), .overflow(ovf[0]),
        .underflow(unf[0]));

    fifomem_thresh #(.WIDTH(4), .DEPTH(6), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(0)) u_d1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full[1]),
        .almost_full(af[1]), .rd_en(rd_en), .rd_data(rd[1]), .empty(empty[1]),
        .almost_empty(ae[1]), .count(cnt1), .clr_err(clr_err), .overflow(ovf[1]),
        .underflow(unf[1]));

    fifomem_thresh #(.WIDTH(4), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_d2 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full[2]),
        .almost_full(af[2]), .rd_en(rd_en), .rd_data(rd[2]), .empty(empty[2]),
        .almost_empty(ae[2]), .count(cnt2), .clr_err(clr_err), .overflow(ovf[2]),
        .underflow(unf[2]));

    assign obs[0] = {full[0], af[0], empty[0], ae[0], cnt0, ovf[0], unf[0], rd[0]};
    assign obs[1] = {full[1], af[1], empty[1], ae[1], {1'b0, cnt1}, ovf[1], unf[1], rd[1]};
    assign obs[2] = {full[2], af[2], empty[2], ae[2], cnt2, ovf[2], unf[2], rd[2]};

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mcnt[k] = 0;
            movf[k] = 1'b0;
            munf[k] = 1'b0;
            mrd[k]  = 4'h0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit f;
            bit e;
            f = (mcnt[k] == mdp[k]);
            e = (mcnt[k] == 0);
            if (clr_err) begin
                movf[k] = 1'b0;
                munf[k] = 1'b0;
            end
            if (wr_en && f) movf[k] = 1'b1;
            if (rd_en && e) munf[k] = 1'b1;
            if (rd_en && !e) begin
                if (mfw[k] == 0) mrd[k] = mdat[k][0];
                for (int i = 0; i < 7; i++) mdat[k][i] = mdat[k][i+1];
                mcnt[k]--;
            end
            if (wr_en && !f) begin
                mdat[k][mcnt[k]] = wr_data;
                mcnt[k]++;
            end
        end
    endtask

    function automatic logic [13:0] model_obs(input int k);
        logic [3:0] r;
        if (mfw[k] != 0) r = (mcnt[k] == 0) ? 4'h0 : mdat[k][0];
        else             r = mrd[k];
        return {mcnt[k] == mdp[k], mcnt[k] >= maf[k], mcnt[k] == 0, mcnt[k] <= mae[k],
                4'(mcnt[k]), movf[k], munf[k], r};
    endfunction

    // One clock edge; the model sees the same inputs the DUTs sample.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs[0] !== 14'b0011_0000_00_0000) begin
            n_err++;
            $display("FAIL reset_state obs=%b exp=%b", obs[0], 14'b0011_0000_00_0000);
        end
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs[k] !== model_obs(k)) begin
                n_err++;
                $display("FAIL reset_model dut%0d obs=%b exp=%b", k, obs[k], model_obs(k));
            end
        end
    endtask

    task automatic test_fill_overflow();
        wr_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_data = 4'(i);
            tick();
            n_vec++;
            if (cnt0 !== 4'(i) || ae[0] !== (i <= 2) || af[0] !== (i >= 6) || full[0] !== (i == 8)) begin
                n_err++;
                $display("FAIL fill_flags i=%0d cnt=%0d ae=%b af=%b full=%b", i, cnt0, ae[0], af[0], full[0]);
            end
        end
        wr_data = 4'hF;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (cnt0 !== 4'd8 || ovf[0] !== 1'b1) begin
            n_err++;
            $display("FAIL overflow cnt=%0d ovf=%b exp cnt=8 ovf=1", cnt0, ovf[0]);
        end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_vec++;
        if (ovf[0] !== 1'b0 || obs[0] !== model_obs(0)) begin
            n_err++;
            $display("FAIL clr_err ovf=%b obs=%b exp=%b", ovf[0], obs[0], model_obs(0));
        end
    endtask

    task automatic test_drain_underflow();
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_vec++;
            if (rd[0] !== 4'(i) || empty[0] !== (i == 8)) begin
                n_err++;
                $display("FAIL drain i=%0d rd=%h empty=%b exp rd=%h", i, rd[0], empty[0], 4'(i));
            end
        end
        tick();
        rd_en = 1'b0;
        n_vec++;
        if (unf[0] !== 1'b1 || rd[0] !== 4'h8) begin
            n_err++;
            $display("FAIL underflow unf=%b rd=%h exp unf=1 rd=8", unf[0], rd[0]);
        end
    endtask

    task automatic test_simultaneous();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 4'($urandom);
            tick();
        end
        rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 4'($urandom);
            tick();
            n_vec++;
            if (cnt0 !== 4'd4 || obs[0] !== model_obs(0)) begin
                n_err++;
                $display("FAIL simul_steady cnt=%0d obs=%b exp=%b", cnt0, obs[0], model_obs(0));
            end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++;
            if (obs[0] !== model_obs(0)) begin
                n_err++;
                $display("FAIL simul_order i=%0d obs=%b exp=%b", i, obs[0], model_obs(0));
            end
        end
        wr_en = 1'b1;
        wr_data = 4'h5;
        tick();
        n_vec++;
        if (cnt0 !== 4'd1 || unf[0] !== 1'b1 || ovf[0] !== 1'b0) begin
            n_err++;
            $display("FAIL simul_empty cnt=%0d unf=%b ovf=%b exp cnt=1 unf=1 ovf=0", cnt0, unf[0], ovf[0]);
        end
        rd_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wr_data = 4'($urandom);
            tick();
        end
        rd_en = 1'b1;
        tick();
        n_vec++;
        if (cnt0 !== 4'd7 || ovf[0] !== 1'b1 || rd[0] !== 4'h5) begin
            n_err++;
            $display("FAIL simul_full cnt=%0d ovf=%b rd=%h exp cnt=7 ovf=1 rd=5", cnt0, ovf[0], rd[0]);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_wrap_depth6();
        do_reset();
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 4'($urandom);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rd_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wr_data = 4'(10 + i);
            tick();
            n_vec++;
            if (full[1] !== (i == 5) || cnt1 !== 3'(i + 1)) begin
                n_err++;
                $display("FAIL wrap_full i=%0d full=%b cnt=%0d", i, full[1], cnt1);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_vec++;
            if (rd[1] !== 4'(10 + i)) begin
                n_err++;
                $display("FAIL wrap_data i=%0d rd=%h exp=%h", i, rd[1], 4'(10 + i));
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_fwft_reset();
        do_reset();
        wr_en = 1'b1;
        wr_data = 4'hA;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (rd[2] !== 4'hA || empty[2] !== 1'b0) begin
            n_err++;
            $display("FAIL fwft_show rd=%h empty=%b exp rd=a empty=0", rd[2], empty[2]);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        n_vec++;
        if (rd[2] !== 4'h0 || empty[2] !== 1'b1) begin
            n_err++;
            $display("FAIL fwft_pop rd=%h empty=%b exp rd=0 empty=1", rd[2], empty[2]);
        end
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = 4'($urandom);
            tick();
        end
        wr_en = 1'b0;
        n_vec++;
        if (cnt2 !== 4'd5 || obs[2] !== model_obs(2)) begin
            n_err++;
            $display("FAIL fwft_fill cnt=%0d obs=%b exp=%b", cnt2, obs[2], model_obs(2));
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if (cnt2 !== 4'd0 || empty[2] !== 1'b1 || rd[2] !== 4'h0 || cnt0 !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset cnt2=%0d empty=%b rd=%h cnt0=%0d", cnt2, empty[2], rd[2], cnt0);
        end
        tick();
        reset = 1'b1;
        wr_en = 1'b1;
        wr_data = 4'h3;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (rd[2] !== 4'h3 || rd[0] !== 4'h0) begin
            n_err++;
            $display("FAIL post_reset rd2=%h rd0=%h exp rd2=3 rd0=0", rd[2], rd[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int wbias;
            wbias   = ((c / 100) % 2 == 0) ? 75 : 30;
            wr_en   = ($urandom_range(99) < wbias);
            rd_en   = ($urandom_range(99) < (100 - wbias));
            clr_err = ($urandom_range(99) < 5);
            wr_data = 4'($urandom);
            tick();
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs[k] !== model_obs(k)) begin
                    n_err++;
                    $display("FAIL random c=%0d dut%0d obs=%b exp=%b", c, k, obs[k], model_obs(k));
                end
            end
        end
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_overflow();
        test_drain_underflow();
        test_simultaneous();
        test_wrap_depth6();
        test_fwft_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
